// File: rtl/fc_a3_layer.sv
// fc_a3_layer -- fully-connected stage after the 5x5 conv stage (C5 -> F6).
//
// Walks the IN_NEURONS-word upstream activation buffer once per output neuron.
// Each cycle it does one MAC: sum(w*x) + bias. It writes OUT_NEURONS results into
// the next stage's IFM buffer. Weights and biases sit in internal RAMs that the
// host loads.
//
// Build option:
//   FC_A3_RELU_EN  when defined, negative results are clamped to 0 after
//                  saturation. Latency is the same in both builds.
//
// Ports:
//   clk, reset                  clock; asynchronous active-low reset
//   riscv_data / riscv_address  host write data / word address
//   wm_enable_write             host write strobe, weight RAM (addr = n*IN+i)
//   bm_enable_write             host write strobe, bias RAM (addr = n, low bits)
//   start_from_previous         upstream buffer complete (1-cycle pulse)
//   data_in_from_previous       upstream read data, 1 cycle after the address
//   ifm_enable_read_current     upstream read enable
//   ifm_address_read_current    upstream read address (input index i)
//   end_to_previous             upstream buffer released (1-cycle pulse)
//   ready                       high only while idle
//   end_from_next               next stage released its buffer (1-cycle pulse)
//   data_out_for_next           result word
//   ifm_enable_write_next       next-buffer write strobe
//   ifm_address_write_next      next-buffer write address (neuron index n)
//   start_to_next               frame of results complete (1-cycle pulse)
module fc_a3_layer #(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAC_BITS    = 16,
  parameter int IN_NEURONS   = 120,
  parameter int OUT_NEURONS  = 84,
  parameter int ADDRESS_BITS = 15,
  localparam int IA = (IN_NEURONS  > 1) ? $clog2(IN_NEURONS)  : 1,
  localparam int OA = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   riscv_data,
  input  logic [ADDRESS_BITS-1:0] riscv_address,
  input  logic                    wm_enable_write,
  input  logic                    bm_enable_write,
  input  logic                    start_from_previous,
  input  logic [DATA_WIDTH-1:0]   data_in_from_previous,
  output logic                    ifm_enable_read_current,
  output logic [IA-1:0]           ifm_address_read_current,
  output logic                    end_to_previous,
  output logic                    ready,
  input  logic                    end_from_next,
  output logic [DATA_WIDTH-1:0]   data_out_for_next,
  output logic                    ifm_enable_write_next,
  output logic [OA-1:0]           ifm_address_write_next,
  output logic                    start_to_next
);
  localparam int WM_DEPTH = IN_NEURONS * OUT_NEURONS;
  localparam int WA = (WM_DEPTH > 1) ? $clog2(WM_DEPTH) : 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = 2 * DATA_WIDTH + 8;
  localparam logic [IA-1:0] I_LAST = IA'(IN_NEURONS - 1);
  localparam logic [OA-1:0] N_LAST = OA'(OUT_NEURONS - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MAC, S_DRAIN, S_WRITE, S_FINISH} state_t;

  state_t state, state_nxt;
  logic [OA-1:0] n;
  logic [IA-1:0] i;
  logic [WA-1:0] w_ptr;      // walks n*IN+i, because the weights are stored contiguously
  logic          next_busy;
  logic          busy_eff;

  // ---------------- host-loaded RAMs (not cleared by reset) ----------------
  logic [DATA_WIDTH-1:0] wm [WM_DEPTH];
  logic [DATA_WIDTH-1:0] bm [OUT_NEURONS];
  logic [DATA_WIDTH-1:0] wm_q, bm_q;

  always_ff @(posedge clk) begin
    if (wm_enable_write && (int'(riscv_address) < WM_DEPTH))
      wm[riscv_address[WA-1:0]] <= riscv_data;
    if (bm_enable_write && (int'(riscv_address[OA-1:0]) < OUT_NEURONS))
      bm[riscv_address[OA-1:0]] <= riscv_data;
    if (state == S_MAC)
      wm_q <= wm[w_ptr];
    if (state == S_MAC && i == '0)
      bm_q <= bm[n];
  end

  // ---------------- control ----------------
  // A release arriving this cycle already counts as "free". The wait then ends
  // and MAC starts on the very next cycle.
  assign busy_eff = next_busy & ~end_from_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start_from_previous) state_nxt = busy_eff ? S_WAIT : S_MAC;
      S_WAIT:   if (!busy_eff) state_nxt = S_MAC;
      S_MAC:    if (i == I_LAST) state_nxt = S_DRAIN;
      S_DRAIN:  state_nxt = S_WRITE;
      S_WRITE:  state_nxt = (n == N_LAST) ? S_FINISH : S_MAC;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n     <= '0;
      i     <= '0;
      w_ptr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          n     <= '0;
          i     <= '0;
          w_ptr <= '0;
        end
        S_MAC: begin
          w_ptr <= w_ptr + WA'(1);
          i     <= (i == I_LAST) ? '0 : i + IA'(1);
        end
        S_WRITE: if (n != N_LAST) n <= n + OA'(1);
        default: ;
      endcase
    end
  end

  // Setting the flag in FINISH takes priority over a release in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                next_busy <= 1'b0;
    else if (state == S_FINISH) next_busy <= 1'b1;
    else if (end_from_next)    next_busy <= 1'b0;
  end

  // ---------------- datapath (one cycle behind the reads) ----------------
  logic                 mac_vld, mac_first;
  logic signed [PW-1:0] x_ext, w_ext, prod;
  logic signed [AW-1:0] prod_ext, bias_ext, acc, sh;
  logic [DATA_WIDTH-1:0] sat, res;

  assign x_ext    = {{DATA_WIDTH{data_in_from_previous[DATA_WIDTH-1]}}, data_in_from_previous};
  assign w_ext    = {{DATA_WIDTH{wm_q[DATA_WIDTH-1]}}, wm_q};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign bias_ext = {{(AW-DATA_WIDTH){bm_q[DATA_WIDTH-1]}}, bm_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_vld   <= 1'b0;
      mac_first <= 1'b0;
      acc       <= '0;
    end else begin
      mac_vld   <= (state == S_MAC);
      mac_first <= (state == S_MAC) && (i == '0);
      if (mac_vld)
        acc <= mac_first ? (bias_ext <<< FRAC_BITS) + prod_ext : acc + prod_ext;
    end
  end

  assign sh  = acc >>> FRAC_BITS;
  assign sat = (sh > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] :
               (sh < SAT_MIN) ? SAT_MIN[DATA_WIDTH-1:0] : sh[DATA_WIDTH-1:0];
`ifdef FC_A3_RELU_EN
  assign res = sat[DATA_WIDTH-1] ? '0 : sat;
`else
  assign res = sat;
`endif

  // ---------------- outputs (all zero in reset except ready) ----------------
  assign ready                    = (state == S_IDLE);
  assign ifm_enable_read_current  = (state == S_MAC);
  assign ifm_address_read_current = (state == S_MAC) ? i : '0;
  assign ifm_enable_write_next    = (state == S_WRITE);
  assign ifm_address_write_next   = (state == S_WRITE) ? n : '0;
  assign data_out_for_next        = (state == S_WRITE) ? res : '0;
  assign start_to_next            = (state == S_FINISH);
  assign end_to_previous          = (state == S_FINISH);

endmodule

// File: tb/tb_fc_a3_layer.sv
module tb_fc_a3_layer;
  localparam int DW = 32;
  localparam int IN = 4;
  localparam int OUT = 2;
  localparam int AB = 15;
  localparam logic [39:0] RST_OUTS = 40'h80_0000_0000;   // only ready set

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] riscv_data;
  logic [AB-1:0] riscv_address;
  logic          wm_enable_write, bm_enable_write;
  logic          start_from_previous;
  logic [DW-1:0] data_in_from_previous;
  logic          ifm_enable_read_current;
  logic [1:0]    ifm_address_read_current;
  logic          end_to_previous, ready, end_from_next;
  logic [DW-1:0] data_out_for_next;
  logic          ifm_enable_write_next;
  logic [0:0]    ifm_address_write_next;
  logic          start_to_next;

  fc_a3_layer #(.DATA_WIDTH(DW), .FRAC_BITS(16), .IN_NEURONS(IN), .OUT_NEURONS(OUT),
                .ADDRESS_BITS(AB)) dut (
    .clk(clk), .reset(reset), .riscv_data(riscv_data), .riscv_address(riscv_address),
    .wm_enable_write(wm_enable_write), .bm_enable_write(bm_enable_write),
    .start_from_previous(start_from_previous), .data_in_from_previous(data_in_from_previous),
    .ifm_enable_read_current(ifm_enable_read_current),
    .ifm_address_read_current(ifm_address_read_current),
    .end_to_previous(end_to_previous), .ready(ready), .end_from_next(end_from_next),
    .data_out_for_next(data_out_for_next), .ifm_enable_write_next(ifm_enable_write_next),
    .ifm_address_write_next(ifm_address_write_next), .start_to_next(start_to_next));

  always #5 clk = ~clk;

  // upstream activation buffer: synchronous read, 1-cycle latency
  logic [3:0][DW-1:0] x_mem;
  always @(posedge clk)
    if (ifm_enable_read_current) data_in_from_previous <= x_mem[ifm_address_read_current];

  typedef struct {
    string              nm;
    logic [3:0][DW-1:0] x;
    logic [7:0][DW-1:0] w;   // index n*IN+i
    logic [1:0][DW-1:0] b;
    logic [1:0][DW-1:0] e;   // expected results, neuron 0 and 1
  } vec_t;
  typedef struct packed { logic [0:0] a; logic [DW-1:0] d; } exp_t;

  vec_t tbl[4];
  exp_t q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, t_start = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] outs();
    return {ready, ifm_enable_read_current, ifm_address_read_current, end_to_previous,
            data_out_for_next, ifm_enable_write_next, ifm_address_write_next, start_to_next};
  endfunction

  // advance one cycle; sample on the falling edge and score any result write
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (reset && ifm_enable_write_next) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexp_wr addr=%0d data=%h required=no write",
                 ifm_address_write_next, data_out_for_next);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 64'(ifm_address_write_next), 64'(e.a));
        chk("wr_data", 64'(data_out_for_next), 64'(e.d));
      end
    end
  endtask

  task automatic load(input int v);
    for (int k = 0; k < IN*OUT; k++) begin
      wm_enable_write = 1'b1; riscv_address = AB'(k); riscv_data = tbl[v].w[k];
      tick();
    end
    wm_enable_write = 1'b0;
    for (int k = 0; k < OUT; k++) begin
      bm_enable_write = 1'b1; riscv_address = AB'(k); riscv_data = tbl[v].b[k];
      tick();
    end
    bm_enable_write = 1'b0;
    x_mem = tbl[v].x;
  endtask

  task automatic start_frame(input int v, input int nw);
    exp_t e;
    for (int k = 0; k < nw; k++) begin
      e.a = 1'(k); e.d = tbl[v].e[k];
      q.push_back(e);
    end
    start_from_previous = 1'b1;
    t_start = cyc;
    tick();
    start_from_previous = 1'b0;
  endtask

  // wait for start_to_next; optionally release the next buffer in that same cycle
  task automatic wait_fin(input int exp_lat, input bit end_same);
    bit done = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (start_to_next) begin done = 1'b1; break; end
      tick();
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL fin_timeout actual=no start_to_next required=pulse");
    end else begin
      if (exp_lat >= 0) chk("latency", 64'(cyc - t_start), 64'(exp_lat));
      chk("end_prev", 64'(end_to_previous), 64'd1);
      end_from_next = end_same;
      tick();
      end_from_next = 1'b0;
      chk("s2n_pulse", 64'(start_to_next), 64'd0);
    end
  endtask

  task automatic free_next();
    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
  endtask

  initial begin
    bit seen;
    // vectors (packed arrays: leftmost word is the highest index)
    tbl[0].nm = "identity";
    tbl[0].x  = {32'h00040000, 32'h00030000, 32'h00020000, 32'h00010000};
    tbl[0].w  = {{4{32'h00008000}}, {4{32'h00010000}}};
    tbl[0].b  = {32'hFFFF0000, 32'h00004000};
    tbl[0].e  = {32'h00040000, 32'h000A4000};
    tbl[1].nm = "negative";
    tbl[1].x  = {4{32'h00010000}};
    tbl[1].w  = {{4{32'hFFFFC000}}, 32'h0, 32'h0, 32'h0, 32'hFFFD0000};
    tbl[1].b  = '0;
    tbl[2].nm = "saturate";
    tbl[2].x  = {4{32'h7FFF0000}};
    tbl[2].w  = {{4{32'h80010000}}, {4{32'h7FFF0000}}};
    tbl[2].b  = {32'h7FFFFFFF, 32'h7FFFFFFF};
    tbl[3].nm = "floor_shift";
    tbl[3].x  = {32'hFFFE0000, 32'h00018000, 32'hFFFF8000, 32'h00008000};
    tbl[3].w  = {{4{32'h00000001}}, {4{32'h00020000}}};
    tbl[3].b  = '0;
`ifdef FC_A3_RELU_EN
    tbl[1].e  = '0;
    tbl[2].e  = {32'h00000000, 32'h7FFFFFFF};
    tbl[3].e  = '0;
`else
    tbl[1].e  = {32'hFFFF0000, 32'hFFFD0000};
    tbl[2].e  = {32'h80000000, 32'h7FFFFFFF};
    tbl[3].e  = {32'hFFFFFFFF, 32'hFFFF0000};
`endif

    // reset: start pulsed while reset is held must do nothing
    reset = 1'b0; riscv_data = '0; riscv_address = '0;
    wm_enable_write = 1'b0; bm_enable_write = 1'b0; end_from_next = 1'b0;
    start_from_previous = 1'b1; x_mem = '0;
    tick(); tick();
    chk("rst_outs", 64'(outs()), 64'(RST_OUTS));
    start_from_previous = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("post_rst_idle", 64'(outs()), 64'(RST_OUTS));

    // table-driven frames, next stage released after each one
    for (int v = 0; v < 4; v++) begin
      load(v);
      start_frame(v, OUT);
      wait_fin(OUT*(IN+2)+1, 1'b0);
      chk("q_empty", 64'(q.size()), 64'd0);
      free_next();
    end

    // backpressure: frame leaves next stage busy, second start must wait
    load(0);
    start_frame(0, OUT);
    wait_fin(13, 1'b0);
    start_frame(0, OUT);
    chk("wait_not_ready", 64'(ready), 64'd0);
    seen = 1'b0;
    for (int t = 0; t < 5; t++) begin seen |= ifm_enable_read_current; tick(); end
    chk("wait_no_rd", 64'(seen), 64'd0);
    free_next();
    chk("mac_after_end", 64'({ifm_enable_read_current, ifm_address_read_current}), 64'h4);
    wait_fin(-1, 1'b1);                  // release collides with FINISH
    chk("ready_after", 64'(ready), 64'd1);
    start_frame(0, OUT);
    seen = 1'b0;
    for (int t = 0; t < 4; t++) begin seen |= ifm_enable_read_current; tick(); end
    chk("busy_kept", 64'(seen), 64'd0);
    free_next();
    chk("mac_after_end2", 64'(ifm_enable_read_current), 64'd1);
    wait_fin(-1, 1'b0);
    free_next();

    // reset in the middle of neuron 1 (i=2); only neuron 0 gets written
    start_frame(0, 1);
    while (cyc < t_start + 9) tick();
    chk("mid_pos", 64'({ifm_enable_read_current, ifm_address_read_current}), 64'h6);
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", 64'(outs()), 64'(RST_OUTS));
    tick(); tick();
    chk("mid_rst_hold", 64'(outs()), 64'(RST_OUTS));
    reset = 1'b1;
    tick();
    chk("abort_q", 64'(q.size()), 64'd0);
    start_frame(0, OUT);                 // reset cleared next_busy: full latency
    wait_fin(13, 1'b0);
    chk("final_q", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
